// File: rtl/serial_mod_pkg.sv
// Shared types and constants for the serial modulus checker.
// Build option: define SERIAL_MOD_LSB_EN to enable LSB-first bit order.
package serial_mod_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic ORDER_MSB = 1'b0;
  localparam logic ORDER_LSB = 1'b1;

endpackage

// File: rtl/serial_mod_step.sv
// One modular accumulation step: r' from (r, din, w, mode) for a fixed DIVISOR.
// Sums stay RW+1 bits wide and are folded back by one conditional subtract,
// which is enough because both step forms stay below 2*DIVISOR.
module serial_mod_step
  import serial_mod_pkg::*;
#(
  parameter int DIVISOR = 5,
  localparam int RW = $clog2(DIVISOR)
) (
  input  logic [RW-1:0] r_i,
  input  logic          din_i,
  input  logic [RW-1:0] w_i,
  input  logic          mode_i,
  output logic [RW-1:0] r_o
);

  localparam logic [RW:0] DIV_EXT = (RW+1)'(DIVISOR);

  logic [RW:0] sum;

  // Form 2r+din (MSB-first) or r+din*w (LSB-first), then reduce once.
  always_comb begin
    sum = '0;
    if (mode_i == ORDER_LSB) begin
      sum = {1'b0, r_i} + (din_i ? {1'b0, w_i} : '0);
    end else begin
      sum = {r_i, din_i};
    end
    if (sum >= DIV_EXT) begin
      r_o = RW'(sum - DIV_EXT);
    end else begin
      r_o = RW'(sum);
    end
  end

endmodule

// File: rtl/serial_mod_checker.sv
// Serial modulus checker: tracks a framed bit stream's value mod DIVISOR.
// Build option: SERIAL_MOD_LSB_EN adds LSB-first order (weight register w).
// Without it the block is MSB-first only and lsb_first is ignored.
module serial_mod_checker
  import serial_mod_pkg::*;
#(
  parameter int DIVISOR  = 5,
  parameter int MAX_BITS = 32,
  localparam int RW = $clog2(DIVISOR),
  localparam int CW = $clog2(MAX_BITS+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          din_valid,
  input  logic          din,
  input  logic          din_last,
  input  logic          lsb_first,
  output logic [RW-1:0] remainder,
  output logic          divisible,
  output logic [CW-1:0] bit_count,
  output logic          overflow,
  output logic          result_valid,
  output logic          result_divisible
);

  localparam logic [RW-1:0] ONE_W   = RW'(1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BITS);

  state_e        state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          rv_q, rv_d;
  logic          rdiv_q, rdiv_d;

  logic          start_beat;
  logic          bit_acc;
  logic          mode;
  logic [RW-1:0] r_in;
  logic [RW-1:0] w_in;
  logic [RW-1:0] r_step;

  // A start beat begins a frame from any state; other bits count only in RUN.
  assign start_beat = din_valid & start;
  assign bit_acc    = din_valid & (start | (state_q == RUN));
  assign r_in       = start_beat ? '0 : rem_q;

`ifdef SERIAL_MOD_LSB_EN
  logic          order_q, order_d;
  logic [RW-1:0] w_q, w_d;
  logic [RW-1:0] w_step;

  assign mode = start_beat ? lsb_first : order_q;
  assign w_in = start_beat ? ONE_W : w_q;

  // Doubling the weight is an MSB-style step with a zero data bit.
  serial_mod_step #(.DIVISOR(DIVISOR)) u_wstep (
    .r_i    (w_in),
    .din_i  (1'b0),
    .w_i    (ONE_W),
    .mode_i (ORDER_MSB),
    .r_o    (w_step)
  );

  // Latch bit order on the start beat and advance the weight per accepted bit.
  always_comb begin
    order_d = start_beat ? lsb_first : order_q;
    w_d     = bit_acc ? w_step : w_q;
  end

  // Order and weight registers, reset to MSB-first with weight 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      order_q <= ORDER_MSB;
      w_q     <= ONE_W;
    end else begin
      order_q <= order_d;
      w_q     <= w_d;
    end
  end
`else
  logic unused_lsb_first;

  assign mode             = ORDER_MSB;
  assign w_in             = ONE_W;
  assign unused_lsb_first = lsb_first;
`endif

  serial_mod_step #(.DIVISOR(DIVISOR)) u_step (
    .r_i    (r_in),
    .din_i  (din),
    .w_i    (w_in),
    .mode_i (mode),
    .r_o    (r_step)
  );

  // Next-state: update on accepted bits, hold on stalls and ignored bits.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    rv_d    = 1'b0;
    rdiv_d  = rdiv_q;
    if (bit_acc) begin
      rem_d = r_step;
      div_d = (r_step == '0);
      if (start_beat) begin
        cnt_d = CW'(1);
        ovf_d = 1'b0;
      end else if (cnt_q == MAX_CNT) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (din_last) begin
        state_d = IDLE;
        rv_d    = 1'b1;
        rdiv_d  = (r_step == '0);
      end else if (start_beat) begin
        state_d = RUN;
      end
    end
  end

  // Main state registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      div_q   <= 1'b1;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rv_q    <= 1'b0;
      rdiv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rv_q    <= rv_d;
      rdiv_q  <= rdiv_d;
    end
  end

  assign remainder        = rem_q;
  assign divisible        = div_q;
  assign bit_count        = cnt_q;
  assign overflow         = ovf_q;
  assign result_valid     = rv_q;
  assign result_divisible = rdiv_q;

endmodule

// File: tb/tb_serial_mod_checker.sv
// Bench for serial_mod_checker: two instances (DIVISOR=5/MAX_BITS=4 and
// DIVISOR=3/MAX_BITS=32) share one stimulus stream. A frame-level model keeps
// the received bits and derives outputs with plain integer arithmetic.
// Honours SERIAL_MOD_LSB_EN when defined.
module tb_serial_mod_checker;

  localparam int D0  = 5;
  localparam int MB0 = 4;
  localparam int D1  = 3;
  localparam int MB1 = 32;
  localparam int RW0 = $clog2(D0);
  localparam int CW0 = $clog2(MB0+1);
  localparam int RW1 = $clog2(D1);
  localparam int CW1 = $clog2(MB1+1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic din_last = 1'b0;
  logic lsb_first = 1'b0;

  logic [RW0-1:0] rem0;
  logic           div0, ovf0, rv0, rdiv0;
  logic [CW0-1:0] cnt0;
  logic [RW1-1:0] rem1;
  logic           div1, ovf1, rv1, rdiv1;
  logic [CW1-1:0] cnt1;

  always #5 clk = ~clk;

  serial_mod_checker #(.DIVISOR(D0), .MAX_BITS(MB0)) u_dut5 (
    .clk(clk), .reset(reset), .start(start), .din_valid(din_valid), .din(din),
    .din_last(din_last), .lsb_first(lsb_first), .remainder(rem0), .divisible(div0),
    .bit_count(cnt0), .overflow(ovf0), .result_valid(rv0), .result_divisible(rdiv0)
  );

  serial_mod_checker #(.DIVISOR(D1), .MAX_BITS(MB1)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .din_valid(din_valid), .din(din),
    .din_last(din_last), .lsb_first(lsb_first), .remainder(rem1), .divisible(div1),
    .bit_count(cnt1), .overflow(ovf1), .result_valid(rv1), .result_divisible(rdiv1)
  );

  // Frame-level model state
  bit frameBits[64];
  int frameLen;
  bit inFrame;
  bit frameLsb;
  int expRem[2], expDiv[2], expCnt[2], expOvf[2], expRv[2], expRdiv[2];
  int divs[2] = '{D0, D1};
  int maxb[2] = '{MB0, MB1};

  int checks = 0;
  int errors = 0;

  // Value of the current frame (per its bit order) modulo d
  function automatic int frameMod(input int d);
    longint unsigned v;
    v = 0;
    for (int i = 0; i < frameLen; i++) begin
      if (frameLsb) begin
        if (frameBits[i]) v = v + (64'd1 << i);
      end else begin
        v = v * 2;
        if (frameBits[i]) v = v + 1;
      end
    end
    return int'(v % longint'(d));
  endfunction

  task automatic modelReset();
    frameLen = 0;
    inFrame  = 1'b0;
    frameLsb = 1'b0;
    for (int k = 0; k < 2; k++) begin
      expRem[k] = 0; expDiv[k] = 1; expCnt[k] = 0;
      expOvf[k] = 0; expRv[k] = 0; expRdiv[k] = 0;
    end
  endtask

  // Model update on every clock edge or reset assertion
  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        modelReset();
      end else begin
        for (int k = 0; k < 2; k++) expRv[k] = 0;
        if (din_valid && (start || inFrame)) begin
          if (start) begin
            frameLen = 0;
`ifdef SERIAL_MOD_LSB_EN
            frameLsb = lsb_first;
`else
            frameLsb = 1'b0;
`endif
          end
          frameBits[frameLen] = din;
          frameLen++;
          inFrame = !din_last;
          for (int k = 0; k < 2; k++) begin
            expRem[k] = frameMod(divs[k]);
            expDiv[k] = (expRem[k] == 0) ? 1 : 0;
            expCnt[k] = (frameLen > maxb[k]) ? maxb[k] : frameLen;
            expOvf[k] = (frameLen > maxb[k]) ? 1 : 0;
            if (din_last) begin
              expRv[k]   = 1;
              expRdiv[k] = expDiv[k];
            end
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("rem5",  int'(rem0),  expRem[0]);
    checkOutput("div5",  int'(div0),  expDiv[0]);
    checkOutput("cnt5",  int'(cnt0),  expCnt[0]);
    checkOutput("ovf5",  int'(ovf0),  expOvf[0]);
    checkOutput("rv5",   int'(rv0),   expRv[0]);
    checkOutput("rdiv5", int'(rdiv0), expRdiv[0]);
    checkOutput("rem3",  int'(rem1),  expRem[1]);
    checkOutput("div3",  int'(div1),  expDiv[1]);
    checkOutput("cnt3",  int'(cnt1),  expCnt[1]);
    checkOutput("ovf3",  int'(ovf1),  expOvf[1]);
    checkOutput("rv3",   int'(rv1),   expRv[1]);
    checkOutput("rdiv3", int'(rdiv1), expRdiv[1]);
  endtask

  // One cycle: compare on the falling edge, then step to just after the rising edge
  task automatic tick();
    @(negedge clk);
    compareAll();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input bit s, input bit d, input bit l, input bit lsb);
    start = s; din = d; din_last = l; lsb_first = lsb; din_valid = 1'b1;
    tick();
    din_valid = 1'b0; start = 1'b0; din_last = 1'b0;
  endtask

  // Send nbits of value; LSB order sends value[0] first, else value[nbits-1]
  task automatic sendFrame(input int value, input int nbits, input bit lsb);
    logic [31:0] v;
    v = value;
    for (int i = 0; i < nbits; i++) begin
      applyStimulus(i == 0, lsb ? v[i] : v[nbits-1-i], i == nbits-1, lsb);
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    idle(2);
    checkOutput("rstRem",  int'(rem0),  0);
    checkOutput("rstDiv",  int'(div0),  1);
    checkOutput("rstCnt",  int'(cnt0),  0);
    checkOutput("rstRdiv", int'(rdiv0), 0);
    reset = 1'b1;
    idle(1);

    // 1010 = 10 MSB-first
    sendFrame(10, 4, 1'b0);
    checkOutput("ten_rem5",   int'(rem0),  0);
    checkOutput("ten_rv5",    int'(rv0),   1);
    checkOutput("ten_rdiv5",  int'(rdiv0), 1);
    checkOutput("ten_rem3",   int'(rem1),  1);
    checkOutput("ten_model5", expRem[0],   0);
    idle(1);
    checkOutput("ten_rvgone", int'(rv0),   0);

    // 111 = 7 with two-cycle gaps between bits
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("seven_rem5",  int'(rem0),  2);
    checkOutput("seven_rv5",   int'(rv0),   1);
    checkOutput("seven_rdiv5", int'(rdiv0), 0);
    checkOutput("seven_model", expRem[0],   2);
    idle(2);

    // 110010 = 50: saturation and overflow on the MAX_BITS=4 instance
    sendFrame(50, 6, 1'b0);
    checkOutput("ovf_cnt5",  int'(cnt0),  4);
    checkOutput("ovf_ovf5",  int'(ovf0),  1);
    checkOutput("ovf_rdiv5", int'(rdiv0), 1);
    checkOutput("ovf_cnt3",  int'(cnt1),  6);
    checkOutput("ovf_rem3",  int'(rem1),  2);
    idle(1);

    // Bit order: 0,1,0,1 sent with lsb_first=1, then MSB-first, then 1,1,0
    sendFrame(10, 4, 1'b1);
    checkOutput("lsb0101_rem5", int'(rem0), 0);
`ifdef SERIAL_MOD_LSB_EN
    checkOutput("lsb0101_rem3", int'(rem1), 1);
`else
    checkOutput("lsb0101_rem3", int'(rem1), 2);
`endif
    sendFrame(5, 4, 1'b0);
    checkOutput("msb0101_rem5", int'(rem0), 0);
    sendFrame(3, 3, 1'b1);
`ifdef SERIAL_MOD_LSB_EN
    checkOutput("lsb110_rem5",  int'(rem0), 3);
    checkOutput("lsb110_model", expRem[0],  3);
`else
    checkOutput("lsb110_rem5",  int'(rem0), 1);
    checkOutput("lsb110_model", expRem[0],  1);
`endif
    idle(1);

    // Reset mid-frame, stray bit after release, then a one-bit frame
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("stray_rv5",  int'(rv0),  0);
    checkOutput("stray_rem5", int'(rem0), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("one_rv5",   int'(rv0),   1);
    checkOutput("one_rdiv5", int'(rdiv0), 1);
    checkOutput("one_cnt5",  int'(cnt0),  1);

    // Restart in RUN: aborted frame produces no pulse
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("restart_rv5",  int'(rv0),  0);
    checkOutput("restart_cnt5", int'(cnt0), 1);
    checkOutput("restart_rem5", int'(rem0), 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("restart_end_rem5",  int'(rem0),  3);
    checkOutput("restart_end_rdiv5", int'(rdiv0), 0);
    idle(1);

    // Every 6-bit value on the DIVISOR=3 instance
    for (int v = 0; v < 64; v++) begin
      sendFrame(v, 6, 1'b0);
      checkOutput("mod3_rdiv", int'(rdiv1), (v % 3 == 0) ? 1 : 0);
    end
    idle(1);

    // Randomized traffic with restarts, stalls and occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 400) == 0) begin
        din_valid = 1'b0;
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
      end
      din_valid = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 9) == 0);
      din       = ($urandom_range(0, 1) == 1);
      din_last  = ($urandom_range(0, 6) == 0) || (frameLen >= 40);
      lsb_first = ($urandom_range(0, 1) == 1);
      tick();
    end
    din_valid = 1'b0; start = 1'b0; din_last = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
